store_rmw_unit: RTL and testbench

//  Store side of the data-memory path; the write-direction counterpart of the load formatter.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/store_merge.sv | 30 +++
 rtl/store_rmw_unit.sv | 88 ++++++++
 tb/tb_store_rmw_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared data-memory definitions: funct3 store codes, the store FSM state type and
// small decode helpers used by both the store unit and the load formatter.
package mem_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StErr   = 2'd3
  } state_t;

  // Any funct3 other than SB/SH behaves as SW.
  function automatic logic is_rmw(input logic [2:0] mode);
    return (mode == F3_SB) || (mode == F3_SH);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] off);
    logic w_mis;
    unique case (mode)
      F3_SB:   w_mis = 1'b0;
      F3_SH:   w_mis = (off == 2'd3);
      default: w_mis = (off != 2'd0);
    endcase
    return w_mis;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge for sub-word stores: overlays SB/SH data onto the old word.
// Non-SB/SH modes pass the store data through unchanged.
module store_merge
  import mem_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_mode,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    if (!is_rmw(i_mode)) begin
      o_merged = i_data;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (k[1:0] == i_offset) begin
          o_merged[8*k +: 8] = i_data[7:0];
        end
        // Upper half of SH lands one lane above the offset; offset 3 never reaches here.
        if (i_mode == F3_SH && i_offset != 2'd3 && k[1:0] == i_offset + 2'd1) begin
          o_merged[8*k +: 8] = i_data[15:8];
        end
      end
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store path to a byte-enable-less word RAM: SW writes directly, SB/SH read-merge-write,
// misaligned requests are rejected with a one-cycle error pulse.
module store_rmw_unit
  import mem_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_data,
  input  logic [2:0]         req_mode,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic               mem_rd_en,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_wdata,
  output logic               done,
  output logic               misalign_err
);

  state_t             r_state;
  state_t             w_state_next;
  logic [A_WIDTH-1:0] r_addr;
  logic [D_WIDTH-1:0] r_data;
  logic [2:0]         r_mode;
  logic               w_accept;
  logic [D_WIDTH-1:0] w_merged;

  assign w_accept = req_valid && (r_state == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_data  <= '0;
      r_mode  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr <= req_addr;
        r_data <= req_data;
        r_mode <= req_mode;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (is_misaligned(req_mode, req_addr[1:0])) begin
            w_state_next = StErr;
          end else if (is_rmw(req_mode)) begin
            w_state_next = StRead;
          end else begin
            w_state_next = StWrite;
          end
        end
      end
      StRead:  w_state_next = StWrite;
      StWrite: w_state_next = StIdle;
      StErr:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  store_merge u_merge (
    .i_old    (mem_rdata),
    .i_data   (r_data),
    .i_offset (r_addr[1:0]),
    .i_mode   (r_mode),
    .o_merged (w_merged)
  );

  assign req_ready    = (r_state == StIdle);
  assign mem_addr     = {r_addr[A_WIDTH-1:2], 2'b00};
  assign mem_rd_en    = (r_state == StRead);
  assign mem_we       = (r_state == StWrite);
  assign done         = (r_state == StWrite);
  assign misalign_err = (r_state == StErr);
  assign mem_wdata    = (r_state == StWrite) ? w_merged : '0;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Scoreboard bench for store_rmw_unit: a driver pushes expected writes/errors computed
// from a shadow memory; a negedge monitor pops and compares what the DUT presents.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [2:0]  req_mode = '0;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata = '0;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        done;
  logic        misalign_err;

  store_rmw_unit #(.D_WIDTH(32), .A_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_mode     (req_mode),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .done         (done),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          rmw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ram[16];
  logic [31:0] shadow[16];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_writes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // RAM the DUT talks to: synchronous read, no byte enables
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr[5:2]];
    if (mem_we) ram[mem_addr[5:2]] <= mem_wdata;
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      chk("done_eq_we", {31'd0, done}, {31'd0, mem_we});
      if (mem_rd_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 32'd1, 32'd0);
        end else begin
          chk("read_is_rmw", {31'd0, exp_q[0].rmw && !exp_q[0].err}, 32'd1);
          chk("read_addr", mem_addr, exp_q[0].addr);
          chk("read_cycle", cyc, exp_q[0].cyc - 1);
        end
      end
      if (mem_we || misalign_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, mem_we, misalign_err}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          if (e.err) begin
            chk("err_pulse", {30'd0, mem_we, misalign_err}, 32'd1);
          end else begin
            chk("write_kind", {30'd0, mem_we, misalign_err}, 32'd2);
            chk("write_addr", mem_addr, e.addr);
            chk("write_data", mem_wdata, e.wdata);
            n_writes++;
          end
        end
      end
    end
  end

  // Reference: compute the expected outcome of one accepted request
  function automatic exp_t model(input logic [2:0] mode, input logic [31:0] addr,
                                 input logic [31:0] data, input int acc_cyc);
    exp_t        e;
    int          o;
    logic [31:0] old;
    o       = int'(addr[1:0]);
    e.addr  = {addr[31:2], 2'b00};
    e.rmw   = (mode == 3'b000) || (mode == 3'b001);
    e.err   = (mode == 3'b001) ? (o == 3) : (mode == 3'b000) ? 1'b0 : (o != 0);
    e.cyc   = acc_cyc + ((e.rmw && !e.err) ? 1 : 0);
    old     = shadow[addr[5:2]];
    e.wdata = data;
    if (mode == 3'b000)
      e.wdata = (old & ~(32'hFF << (8 * o))) | ((data & 32'hFF) << (8 * o));
    else if (mode == 3'b001)
      e.wdata = (old & ~(32'hFFFF << (8 * o))) | ((data & 32'hFFFF) << (8 * o));
    if (!e.err) shadow[addr[5:2]] = e.wdata;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge
  task automatic issue(input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] data, input bit hold);
    int t = 0;
    req_valid = 1'b1;
    req_mode  = mode;
    req_addr  = addr;
    req_data  = data;
    while (!req_ready) begin
      @(posedge clk); #1;
      t++;
      if (t > 20) begin
        chk("ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(model(mode, addr, data, cyc + 1));
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 16; i++) begin
      ram[i]    = $urandom;
      shadow[i] = ram[i];
    end
    ram[8]    = 32'h11223344;
    shadow[8] = 32'h11223344;

    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_strobes", {28'd0, mem_rd_en, mem_we, done, misalign_err}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(3'b010, 32'h10, 32'hDEADBEEF, 0);
    drain();
    issue(3'b000, 32'h22, 32'h000000AB, 0);
    drain();
    chk("sb_ram", ram[8], 32'h11AB3344);
    ram[8]    = 32'h11223344;
    shadow[8] = 32'h11223344;
    issue(3'b001, 32'h21, 32'h0000CAFE, 0);
    drain();
    chk("sh1_ram", ram[8], 32'h11CAFE44);
    ram[8]    = 32'h11223344;
    shadow[8] = 32'h11223344;
    issue(3'b001, 32'h22, 32'h0000CAFE, 0);
    drain();
    chk("sh2_ram", ram[8], 32'hCAFE3344);
    issue(3'b001, 32'h23, 32'h12345678, 0);
    issue(3'b010, 32'h06, 32'h12345678, 0);
    drain();

    // Reset during the READ cycle of an SB: no write may follow
    req_valid = 1'b1;
    req_mode  = 3'b000;
    req_addr  = 32'h24;
    req_data  = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("in_read", {31'd0, mem_rd_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_strobes", {29'd0, mem_rd_en, mem_we, misalign_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(3'b010, 32'h30, 32'hA5A5A5A5, 0);
    drain();

    // Hold valid for 6 cycles of SW (mode 111): only every other cycle accepts
    w0 = n_writes;
    req_valid = 1'b1;
    req_mode  = 3'b111;
    req_addr  = 32'h14;
    req_data  = 32'h0BADF00D;
    for (int i = 0; i < 6; i++) begin
      if (req_ready) exp_q.push_back(model(req_mode, req_addr, req_data, cyc + 1));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain();
    chk("held_sw_writes", n_writes - w0, 32'd3);

    for (int i = 0; i < 200; i++) begin
      issue(3'($urandom_range(0, 7)), $urandom & 32'h3F, $urandom, 1'($urandom));
    end
    req_valid = 1'b0;
    drain();
    for (int i = 0; i < 16; i++) chk("final_ram", ram[i], shadow[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
